// File: rtl/lu_band_collector.sv
// Output collector for the LU band systolic array: owns the frame slot counter, de-skews the
// seven result lanes into a 44-entry band LU store and exposes it through a registered read port.
module lu_band_collector #(
   parameter int unsigned W       = 8,
   parameter int unsigned LATENCY = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] oL1,
   input  logic [W-1:0] oL2,
   input  logic [W-1:0] oL3,
   input  logic [W-1:0] oL4,
   input  logic [W-1:0] oL5,
   input  logic [W-1:0] oL6,
   input  logic [W-1:0] oL7,
   output logic [4:0]   feed_count,
   output logic         busy,
   output logic         done,
   input  logic [2:0]   rd_row,
   input  logic [2:0]   rd_col,
   output logic [W-1:0] rd_data
);

   localparam logic [5:0] CntLast = 6'(LATENCY + 21);
   localparam logic [5:0] Lat6    = 6'(LATENCY);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e       state_q;
   logic [5:0]   cnt_q;
   logic [5:0]   cnt_inc;
   logic [5:0]   slot;
   logic         cap_valid;
   logic         busy_q;
   logic         done_q;
   logic [4:0]   feed_q;
   logic [W-1:0] rd_q;
   logic [W-1:0] lanes [1:7];
   logic [W-1:0] band  [8][8];

   assign lanes[1] = oL1;
   assign lanes[2] = oL2;
   assign lanes[3] = oL3;
   assign lanes[4] = oL4;
   assign lanes[5] = oL5;
   assign lanes[6] = oL6;
   assign lanes[7] = oL7;

   assign cnt_inc   = cnt_q + 6'd1;
   assign slot      = cnt_q - Lat6;
   assign cap_valid = (state_q == StRun) && (cnt_q >= Lat6) && (slot <= 6'd21);

   // Outputs are registered from the next-state values so they line up with state_q.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         feed_q  <= 5'd31;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StRun: begin
               cnt_q <= cnt_inc;
               if (cnt_q == CntLast) begin
                  state_q <= StDone;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  feed_q  <= 5'd31;
               end else begin
                  feed_q <= (cnt_inc <= 6'd21) ? cnt_inc[4:0] : 5'd31;
               end
            end
            StIdle, StDone: begin
               if (start) begin
                  state_q <= StRun;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  feed_q  <= 5'd0;
               end else begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
                  feed_q  <= 5'd31;
               end
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
               feed_q  <= 5'd31;
            end
         endcase
      end
   end

   // Element (r,c) leaves the array at slot 3*min(r,c) + 2*|r-c| on lane 4 + (c - r).
   for (genvar r = 0; r < 8; r++) begin : g_row
      for (genvar c = 0; c < 8; c++) begin : g_col
         if (((r > c) ? (r - c) : (c - r)) <= 3) begin : g_band
            localparam int Dist = (r > c) ? (r - c) : (c - r);
            localparam int Base = (r < c) ? r : c;
            localparam logic [5:0] Slot = 6'(3 * Base + 2 * Dist);
            localparam int LaneIdx = 4 + c - r;
            logic [W-1:0] el_q;
            always_ff @(posedge clk) begin
               if (rst) begin
                  el_q <= '0;
               end else if (cap_valid && (slot == Slot)) begin
                  el_q <= lanes[LaneIdx];
               end
            end
            assign band[r][c] = el_q;
         end else begin : g_off
            assign band[r][c] = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q <= '0;
      end else begin
         rd_q <= band[rd_row][rd_col];
      end
   end

   assign feed_count = feed_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign rd_data    = rd_q;

endmodule
